lsu_wb_stage: RTL and testbench

Stage-3 load/store and writeback unit of the 3-stage RISC-V core. Consumes the stage-2/3 pipeline register outputs (PC, ALU result, rd, reg_wr/wr_en/rd_en/wb_sel), runs data-bus transactions through a small FSM with byte-lane alignment, sign/zero extension and a timeout, and drives the register-file write port. Stalls the upstream stages while a memory access is outstanding.

---
 rtl/lsu_wb_stage.sv | 206 ++++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_wb_stage.sv
// Stage-3 load/store + writeback: one data-bus access at a time (IDLE/BUSY/RESP), lane alignment, load extension, timeout.
// Non-memory writeback is same-cycle; loads write 2 cycles after issue plus bus wait states; stall_o holds upstream meanwhile.
module lsu_wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [31:0] pc_s3_i,
  input  logic [31:0] alu_s3_i,
  input  logic [4:0]  rd_s3_i,
  input  logic [31:0] store_data_i,
  input  logic [2:0]  funct3_i,
  input  logic        reg_wr_i,
  input  logic        wr_en_i,
  input  logic        rd_en_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [31:0] csr_rdata_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_be_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_ack_i,
  output logic        stall_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic [31:0] badaddr_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [31:0] r_ldata;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_badaddr;

  logic        w_mem_op;
  logic        w_load;
  logic        w_misal;
  logic        w_misal_evt;
  logic        w_start;
  logic        w_ack;
  logic        w_timeout;
  logic        w_wb_ok;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_lbyte;
  logic [15:0] w_lhalf;
  logic [31:0] w_ldata_ext;

  assign w_mem_op = valid_i & (wr_en_i | rd_en_i);
  assign w_load   = rd_en_i & ~wr_en_i;

  // Size decode: lane enables, replicated store data, alignment fault (reserved sizes fault too).
  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b0000;
    w_wdata = store_data_i;
    case (funct3_i)
      3'd0, 3'd4: begin
        w_be    = 4'b0001 << alu_s3_i[1:0];
        w_wdata = {4{store_data_i[7:0]}};
      end
      3'd1, 3'd5: begin
        w_misal = alu_s3_i[0];
        w_be    = 4'b0011 << {alu_s3_i[1], 1'b0};
        w_wdata = {2{store_data_i[15:0]}};
      end
      3'd2: begin
        w_misal = |alu_s3_i[1:0];
        w_be    = 4'b1111;
      end
      default: w_misal = 1'b1;
    endcase
  end

  always_comb begin
    w_lbyte = 8'h00;
    case (alu_s3_i[1:0])
      2'd0: w_lbyte = dbus_rdata_i[7:0];
      2'd1: w_lbyte = dbus_rdata_i[15:8];
      2'd2: w_lbyte = dbus_rdata_i[23:16];
      default: w_lbyte = dbus_rdata_i[31:24];
    endcase
    w_lhalf = alu_s3_i[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (funct3_i)
      3'd0: w_ldata_ext = {{24{w_lbyte[7]}}, w_lbyte};
      3'd1: w_ldata_ext = {{16{w_lhalf[15]}}, w_lhalf};
      3'd4: w_ldata_ext = {24'h000000, w_lbyte};
      3'd5: w_ldata_ext = {16'h0000, w_lhalf};
      default: w_ldata_ext = dbus_rdata_i;
    endcase
  end

  assign w_misal_evt = (r_state == S_IDLE) & w_mem_op & w_misal;
  assign w_start     = (r_state == S_IDLE) & w_mem_op & ~w_misal;
  assign w_ack       = (r_state == S_BUSY) & dbus_ack_i;
  // An ack arriving on the last allowed cycle still completes the access.
  assign w_timeout   = (r_state == S_BUSY) & ~dbus_ack_i & (r_cnt == LP_TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    stall_o      = 1'b0;
    misaligned_o = 1'b0;
    bus_err_o    = 1'b0;
    w_wb_ok      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_BUSY;
        end
        stall_o      = w_start;
        misaligned_o = w_misal_evt;
        w_wb_ok      = ~w_mem_op;
      end
      S_BUSY: begin
        if (w_ack) begin
          w_state_nxt = S_RESP;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
        stall_o   = ~w_timeout;
        bus_err_o = w_timeout;
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
        w_wb_ok     = w_mem_op & w_load;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (reset) begin
      stall_o      = 1'b0;
      misaligned_o = 1'b0;
      bus_err_o    = 1'b0;
      w_wb_ok      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= 16'd0;
      r_ldata   <= 32'd0;
      r_we      <= 1'b0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_be      <= 4'b0000;
      r_badaddr <= 32'd0;
    end else begin
      if (w_start) begin
        r_addr  <= {alu_s3_i[31:2], 2'b00};
        r_we    <= wr_en_i;
        r_be    <= w_be;
        r_wdata <= w_wdata;
        r_cnt   <= 16'd0;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_ack) begin
        r_ldata <= w_ldata_ext;
      end
      if (w_misal_evt | w_timeout) begin
        r_badaddr <= alu_s3_i;
      end
    end
  end

  assign dbus_req_o   = (r_state == S_BUSY);
  assign dbus_we_o    = r_we;
  assign dbus_addr_o  = r_addr;
  assign dbus_wdata_o = r_wdata;
  assign dbus_be_o    = r_be;
  assign badaddr_o    = r_badaddr;

  assign rf_we_o    = valid_i & reg_wr_i & (rd_s3_i != 5'd0) & w_wb_ok;
  assign rf_waddr_o = rd_s3_i;

  always_comb begin
    case (wb_sel_i)
      2'd0: rf_wdata_o = alu_s3_i;
      2'd1: rf_wdata_o = r_ldata;
      2'd2: rf_wdata_o = pc_s3_i + 32'd4;
      default: rf_wdata_o = csr_rdata_i;
    endcase
  end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Directed bench for lsu_wb_stage: stimulus queues expected bus/RF/fault events, a negedge monitor pops and compares.
module tb_lsu_wb_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i, reg_wr_i, wr_en_i, rd_en_i, dbus_ack_i;
  logic [31:0] pc_s3_i, alu_s3_i, store_data_i, csr_rdata_i, dbus_rdata_i;
  logic [4:0]  rd_s3_i;
  logic [2:0]  funct3_i;
  logic [1:0]  wb_sel_i;
  logic        dbus_req_o, dbus_we_o, stall_o, rf_we_o, misaligned_o, bus_err_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, rf_wdata_o, badaddr_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  rf_waddr_o;

  lsu_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .pc_s3_i(pc_s3_i), .alu_s3_i(alu_s3_i),
    .rd_s3_i(rd_s3_i), .store_data_i(store_data_i), .funct3_i(funct3_i), .reg_wr_i(reg_wr_i),
    .wr_en_i(wr_en_i), .rd_en_i(rd_en_i), .wb_sel_i(wb_sel_i), .csr_rdata_i(csr_rdata_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_wdata_o(dbus_wdata_o), .dbus_be_o(dbus_be_o), .dbus_rdata_i(dbus_rdata_i),
    .dbus_ack_i(dbus_ack_i), .stall_o(stall_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
    .rf_wdata_o(rf_wdata_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o),
    .badaddr_o(badaddr_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; int cyc; } bus_exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; int cyc; } rf_exp_t;
  typedef struct { logic kind; logic [31:0] addr; int cyc; } flt_exp_t;

  bus_exp_t bus_q[$];
  rf_exp_t  rf_q[$];
  flt_exp_t flt_q[$];
  bus_exp_t cur_bus;
  rf_exp_t  e_rf;
  flt_exp_t e_flt;
  logic        prev_req = 1'b0;
  logic        ba_pend = 1'b0;
  logic [31:0] ba_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
      ba_pend  = 1'b0;
    end else begin
      if (ba_pend) begin
        chk("badaddr", badaddr_o, ba_exp);
        ba_pend = 1'b0;
      end
      if (dbus_req_o && !prev_req) begin
        if (bus_q.size() == 0) unexpected("bus_req");
        else begin
          cur_bus = bus_q.pop_front();
          chk("bus_cycle", cyc, cur_bus.cyc);
        end
      end
      if (dbus_req_o) begin
        chk("bus_addr", dbus_addr_o, cur_bus.addr);
        chk("bus_be", {28'd0, dbus_be_o}, {28'd0, cur_bus.be});
        chk("bus_we", {31'd0, dbus_we_o}, {31'd0, cur_bus.we});
        chk("bus_wdata", dbus_wdata_o, cur_bus.wdata);
      end
      prev_req = dbus_req_o;
      if (rf_we_o) begin
        if (rf_q.size() == 0) unexpected("rf_write");
        else begin
          e_rf = rf_q.pop_front();
          chk("rf_waddr", {27'd0, rf_waddr_o}, {27'd0, e_rf.rd});
          chk("rf_wdata", rf_wdata_o, e_rf.data);
          chk("rf_cycle", cyc, e_rf.cyc);
        end
      end
      if (misaligned_o || bus_err_o) begin
        if (flt_q.size() == 0) unexpected("fault");
        else begin
          e_flt = flt_q.pop_front();
          chk("fault_buserr", {31'd0, bus_err_o}, {31'd0, e_flt.kind});
          chk("fault_cycle", cyc, e_flt.cyc);
          ba_exp  = e_flt.addr;
          ba_pend = 1'b1;
        end
      end
    end
  end

  task automatic drive_idle();
    valid_i = 0; reg_wr_i = 0; wr_en_i = 0; rd_en_i = 0; rd_s3_i = 0; funct3_i = 0;
    wb_sel_i = 0; pc_s3_i = 0; alu_s3_i = 0; store_data_i = 0; csr_rdata_i = 0;
  endtask

  task automatic do_alu(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] rd,
                        input logic [1:0] wsel, input logic [31:0] csr, input logic [31:0] exp_data);
    valid_i = 1; reg_wr_i = 1; rd_s3_i = rd; wb_sel_i = wsel;
    pc_s3_i = pc; alu_s3_i = alu; csr_rdata_i = csr;
    if (rd != 5'd0) rf_q.push_back('{rd, exp_data, cyc});
    @(posedge clk); #1;
    drive_idle();
  endtask

  // ack_wait < 0 means the bus never answers.
  task automatic do_mem(input logic [2:0] f3, input logic st, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd, input int ack_wait,
                        input logic [31:0] rdata, input logic mis, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rf);
    int c;
    c = cyc;
    valid_i = 1; wr_en_i = st; rd_en_i = ~st; reg_wr_i = ~st; rd_s3_i = rd; funct3_i = f3;
    alu_s3_i = addr; store_data_i = sdata; wb_sel_i = st ? 2'd0 : 2'd1; pc_s3_i = 32'h400;
    if (mis) begin
      flt_q.push_back('{1'b0, addr, c});
      @(negedge clk); chk("mis_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      drive_idle();
      return;
    end
    bus_q.push_back('{exp_addr, exp_be, st, exp_wdata, c + 1});
    if (ack_wait < 0) flt_q.push_back('{1'b1, addr, c + T});
    else if (!st && rd != 5'd0) rf_q.push_back('{rd, exp_rf, c + 2 + ack_wait});
    @(negedge clk); chk("issue_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    for (int k = 0; k < T; k++) begin
      dbus_ack_i   = (k == ack_wait);
      dbus_rdata_i = (k == ack_wait) ? rdata : 32'hDEAD_0000;
      @(negedge clk);
      chk("busy_stall", {31'd0, stall_o}, (ack_wait < 0 && k == T - 1) ? 32'd0 : 32'd1);
      @(posedge clk); #1;
      dbus_ack_i = 0;
      if (k == ack_wait) break;
    end
    if (ack_wait >= 0) begin
      @(negedge clk); chk("resp_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive_idle();
    dbus_ack_i = 0; dbus_rdata_i = 0;
    valid_i = 1; reg_wr_i = 1; rd_s3_i = 5'd5; alu_s3_i = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_we", {31'd0, rf_we_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    chk("rst_be", {28'd0, dbus_be_o}, 32'd0);
    chk("rst_badaddr", badaddr_o, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    reset = 0;

    do_alu(32'hFFFF_FFFC, 32'h0, 5'd5, 2'd2, 32'h0, 32'h0000_0000);
    do_alu(32'hFFFF_FFFC, 32'h0, 5'd0, 2'd2, 32'h0, 32'h0000_0000);
    do_alu(32'h0000_0100, 32'h1234_5678, 5'd7, 2'd0, 32'h0, 32'h1234_5678);
    do_alu(32'h0000_0100, 32'h0, 5'd31, 2'd3, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Reset while the access at 0x100 is outstanding.
    valid_i = 1; rd_en_i = 1; reg_wr_i = 1; rd_s3_i = 5'd4; funct3_i = 3'd2;
    alu_s3_i = 32'h100; wb_sel_i = 2'd1;
    bus_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0, cyc + 1});
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("midrst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("midrst_stall", {31'd0, stall_o}, 32'd0);
    chk("midrst_addr", dbus_addr_o, 32'd0);
    @(posedge clk); #1;
    drive_idle();
    reset = 0;
    @(posedge clk); #1;
    do_alu(32'h0, 32'hA5A5_0001, 5'd8, 2'd0, 32'h0, 32'hA5A5_0001);

    do_mem(3'd0, 1'b0, 32'h1003, 32'h0, 5'd3, 0, 32'h80FF_FF12, 1'b0, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80);
    do_mem(3'd4, 1'b0, 32'h1003, 32'h0, 5'd3, 0, 32'h80FF_FF12, 1'b0, 32'h1000, 4'b1000, 32'h0, 32'h0000_0080);
    do_mem(3'd1, 1'b0, 32'h1002, 32'h0, 5'd10, 2, 32'h80FF_FF12, 1'b0, 32'h1000, 4'b1100, 32'h0, 32'hFFFF_80FF);
    do_mem(3'd5, 1'b0, 32'h1002, 32'h0, 5'd10, 1, 32'h80FF_FF12, 1'b0, 32'h1000, 4'b1100, 32'h0, 32'h0000_80FF);
    do_mem(3'd2, 1'b0, 32'h1000, 32'h0, 5'd11, 0, 32'h80FF_FF12, 1'b0, 32'h1000, 4'b1111, 32'h0, 32'h80FF_FF12);

    do_mem(3'd1, 1'b1, 32'h2002, 32'h0000_ABCD, 5'd0, 0, 32'h0, 1'b0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'h0);
    do_mem(3'd0, 1'b1, 32'h2001, 32'h0000_0077, 5'd0, 1, 32'h0, 1'b0, 32'h2000, 4'b0010, 32'h7777_7777, 32'h0);
    do_mem(3'd2, 1'b1, 32'h2004, 32'hDEAD_BEEF, 5'd0, 0, 32'h0, 1'b0, 32'h2004, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    do_mem(3'd2, 1'b0, 32'h3002, 32'h0, 5'd9, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
    do_mem(3'd1, 1'b0, 32'h3001, 32'h0, 5'd9, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);
    do_mem(3'd3, 1'b0, 32'h3000, 32'h0, 5'd9, 0, 32'h0, 1'b1, 32'h0, 4'b0000, 32'h0, 32'h0);

    do_mem(3'd2, 1'b0, 32'h4000, 32'h0, 5'd6, -1, 32'h0, 1'b0, 32'h4000, 4'b1111, 32'h0, 32'h0);
    do_mem(3'd2, 1'b0, 32'h4004, 32'h0, 5'd6, T - 1, 32'h1122_3344, 1'b0, 32'h4004, 4'b1111, 32'h0, 32'h1122_3344);

    do_alu(32'h0000_0FFC, 32'h0, 5'd12, 2'd2, 32'h0, 32'h0000_1000);
    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_left", bus_q.size(), 32'd0);
    chk("rf_q_left", rf_q.size(), 32'd0);
    chk("flt_q_left", flt_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
